pipelined_cla_addsub: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor. It is the next generation of the team's single-stage registered CLA adder.
- Adds carry-in, an add/subtract mode, signed-overflow and zero flags, a configurable pipeline depth and valid/ready handshakes on both sides.
- Sits in the datapath between operand-fetch and writeback logic. Sustains one operation per cycle when the consumer is ready.

---
 rtl/pipelined_cla_addsub_if.sv | 30 +++
 rtl/pipelined_cla_addsub.sv | 168 ++++++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_cla_addsub_if.sv
// rtl/pipelined_cla_addsub_if.sv - operand/result handshake bundle for the pipelined CLA adder/subtractor
interface pipelined_cla_addsub_if #(
  parameter int WIDTH = 32
);
  // operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             sub;

  // result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, carry_in, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, carry_in, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, zero
  );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - pipelined carry-lookahead adder/subtractor with valid/ready flow control
module pipelined_cla_addsub #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pipelined_cla_addsub_if.slave  bus
);

  // Each stage resolves one slice; slices are split into BLOCK-bit lookahead groups.
  localparam int SLICE = WIDTH / STAGES;
  localparam int NGRP  = SLICE / BLOCK;

  // Slice adder: returns {carry into slice MSB, carry out of slice, slice sum}.
  // Carries inside a group come from per-bit g/p; the group carry out uses the
  // group G/P so the group-to-group ripple path is one AND-OR per group.
  function automatic logic [SLICE+1:0] slice_add(
    input logic [SLICE-1:0] x,
    input logic [SLICE-1:0] y,
    input logic             cin
  );
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE-1:0] s;
    logic [SLICE:0]   c;
    logic             grp_g;
    logic             grp_p;
    g    = x & y;
    p    = x | y;
    c    = '0;
    c[0] = cin;
    for (int grp = 0; grp < NGRP; grp++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        grp_g = g[grp*BLOCK+i] | (p[grp*BLOCK+i] & grp_g);
        grp_p = grp_p & p[grp*BLOCK+i];
      end
      for (int i = 0; i < BLOCK - 1; i++) begin
        c[grp*BLOCK+i+1] = g[grp*BLOCK+i] | (p[grp*BLOCK+i] & c[grp*BLOCK+i]);
      end
      c[(grp+1)*BLOCK] = grp_g | (grp_p & c[grp*BLOCK]);
    end
    s = x ^ y ^ c[SLICE-1:0];
    return {c[SLICE-1], c[SLICE], s};
  endfunction

  // Stage state: accumulated sum, operands still to be consumed, forwarded carry.
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] carry_d;
  logic [WIDTH-1:0]  acc_q [STAGES];
  logic [WIDTH-1:0]  acc_d [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic              overflow_q;
  logic              overflow_d;
  logic              zero_q;
  logic              zero_d;
  logic [STAGES-1:0] adv;

  // A stage may load when it, or every stage downstream of it, can move on;
  // unrolled so no bit of adv depends on another bit of adv.
  always_comb begin
    logic full;
    adv = '0;
    for (int k = 0; k < STAGES; k++) begin
      full = 1'b1;
      for (int j = k; j < STAGES; j++) begin
        full = full & valid_q[j];
      end
      adv[k] = bus.out_ready | ~full;
    end
  end

  // Per-stage datapath: pick the upstream bundle, add this stage's slice,
  // and load only when the stage advances with a valid bundle behind it.
  always_comb begin
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_acc;
    logic             in_c;
    logic             in_v;
    logic [SLICE+1:0] res;
    int               pk;
    in_a       = '0;
    in_b       = '0;
    in_acc     = '0;
    in_c       = 1'b0;
    in_v       = 1'b0;
    res        = '0;
    pk         = 0;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    for (int k = 0; k < STAGES; k++) begin
      pk = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        in_a   = bus.a;
        in_b   = bus.sub ? ~bus.b : bus.b;
        in_c   = bus.sub ? ~bus.carry_in : bus.carry_in;
        in_acc = '0;
        in_v   = bus.in_valid;
      end else begin
        in_a   = a_q[pk];
        in_b   = b_q[pk];
        in_c   = carry_q[pk];
        in_acc = acc_q[pk];
        in_v   = valid_q[pk];
      end
      res = slice_add(in_a[k*SLICE +: SLICE], in_b[k*SLICE +: SLICE], in_c);

      valid_d[k] = adv[k] ? in_v : valid_q[k];
      acc_d[k]   = acc_q[k];
      a_d[k]     = a_q[k];
      b_d[k]     = b_q[k];
      carry_d[k] = carry_q[k];
      if (adv[k] && in_v) begin
        acc_d[k]                  = in_acc;
        acc_d[k][k*SLICE +: SLICE] = res[SLICE-1:0];
        a_d[k]                    = in_a;
        b_d[k]                    = in_b;
        carry_d[k]                = res[SLICE];
        if (k == STAGES - 1) begin
          overflow_d = res[SLICE+1] ^ res[SLICE];
          zero_d     = (acc_d[k] == '0);
        end
      end
    end
  end

  // Pipeline registers; reset discards every in-flight bundle at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= '0;
      carry_q    <= '0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k] <= acc_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.sum       = acc_q[STAGES-1];
  assign bus.carry_out = carry_q[STAGES-1];
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - self-checking bench for pipelined_cla_addsub
module tb_pipelined_cla_addsub;
  logic clk;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  pipelined_cla_addsub_if #(.WIDTH(8))  bus8 ();
  pipelined_cla_addsub_if #(.WIDTH(16)) bus1 ();
  pipelined_cla_addsub_if #(.WIDTH(16)) bus4 ();

  pipelined_cla_addsub #(.WIDTH(8), .BLOCK(4), .STAGES(2)) dut8 (
    .clk(clk), .reset_n(reset_n), .bus(bus8.slave));
  pipelined_cla_addsub #(.WIDTH(16), .BLOCK(4), .STAGES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave));
  pipelined_cla_addsub #(.WIDTH(16), .BLOCK(4), .STAGES(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4.slave));

  // shared stimulus for the two 16-bit instances
  logic        sw_in_valid;
  logic        sw_out_ready;
  logic        sw_carry_in;
  logic        sw_sub;
  logic [15:0] sw_a;
  logic [15:0] sw_b;

  assign bus1.in_valid  = sw_in_valid;
  assign bus1.out_ready = sw_out_ready;
  assign bus1.carry_in  = sw_carry_in;
  assign bus1.sub       = sw_sub;
  assign bus1.a         = sw_a;
  assign bus1.b         = sw_b;
  assign bus4.in_valid  = sw_in_valid;
  assign bus4.out_ready = sw_out_ready;
  assign bus4.carry_in  = sw_carry_in;
  assign bus4.sub       = sw_sub;
  assign bus4.a         = sw_a;
  assign bus4.b         = sw_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic; returns {zero, overflow, carry_out, sum}.
  function automatic logic [18:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                        input logic cin, input logic s);
    logic [31:0] mask;
    logic [31:0] xe;
    logic [31:0] ye;
    logic [31:0] tot;
    logic [31:0] sm;
    logic        co;
    logic        ov;
    mask = (32'd1 << w) - 32'd1;
    xe   = {16'h0, x} & mask;
    ye   = s ? (~{16'h0, y}) & mask : ({16'h0, y} & mask);
    tot  = xe + ye + ((s ? ~cin : cin) ? 32'd1 : 32'd0);
    sm   = tot & mask;
    co   = tot[w];
    ov   = (xe[w-1] == ye[w-1]) && (sm[w-1] != xe[w-1]);
    return {(sm == 32'd0), ov, co, sm[15:0]};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.sum !== 8'h00 || bus8.carry_out !== 1'b0 ||
        bus8.overflow !== 1'b0 || bus8.zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs actual v=%b s=%h c=%b o=%b z=%b required all 0",
               bus8.out_valid, bus8.sum, bus8.carry_out, bus8.overflow, bus8.zero);
    end
    checks++;
    if (bus8.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready actual=%b required=1", bus8.in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1 || bus1.out_valid !== 1'b0 ||
        bus4.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset actual v8=%b r8=%b v1=%b v4=%b required 0 1 0 0",
               bus8.out_valid, bus8.in_ready, bus1.out_valid, bus4.out_valid);
    end
  endtask

  // One unstalled operation on the 8-bit instance with expected constants and a latency of 2.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc, input logic ts,
                     input logic [7:0] es, input logic ec, input logic eo, input logic ez,
                     input string nm);
    int lat;
    @(negedge clk);
    bus8.in_valid  = 1'b1;
    bus8.a         = ta;
    bus8.b         = tb_v;
    bus8.carry_in  = tc;
    bus8.sub       = ts;
    bus8.out_ready = 1'b1;
    #1;
    checks++;
    if (bus8.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_in_ready actual=%b required=1", nm, bus8.in_ready);
    end
    @(negedge clk);
    bus8.in_valid = 1'b0;
    lat = 1;
    while (bus8.out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 2) begin
      failures++;
      $display("FAIL %s_latency actual=%0d required=2", nm, lat);
    end
    checks++;
    if (bus8.sum !== es || bus8.carry_out !== ec || bus8.overflow !== eo || bus8.zero !== ez) begin
      failures++;
      $display("FAIL %s_result actual s=%h c=%b o=%b z=%b required s=%h c=%b o=%b z=%b",
               nm, bus8.sum, bus8.carry_out, bus8.overflow, bus8.zero, es, ec, eo, ez);
    end
  endtask

  task automatic test_add();
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "add_wrap");
    op8(8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 1'b0, "add_cin");
  endtask

  task automatic test_overflow();
    op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, "ovf_pos");
    op8(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, "ovf_neg");
  endtask

  task automatic test_sub();
    op8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, "sub_neg");
    op8(8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, "sub_borrow");
    op8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, "sub_ovf");
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_q[$];
    logic [7:0] first_res;
    int idx;
    int got;
    first_res = 8'h30;
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
      @(negedge clk);
      bus8.in_valid  = (idx < 5);
      bus8.a         = 8'h10 + 8'(idx);
      bus8.b         = 8'h20 + 8'(idx);
      bus8.carry_in  = 1'b0;
      bus8.sub       = 1'b0;
      bus8.out_ready = (cyc >= 4);
      #1;
      if (cyc == 2 || cyc == 3) begin
        checks++;
        if (bus8.in_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_in_ready_low cyc=%0d actual=%b required=0", cyc, bus8.in_ready);
        end
        checks++;
        if (bus8.out_valid !== 1'b1 || bus8.sum !== first_res) begin
          failures++;
          $display("FAIL bp_hold cyc=%0d actual v=%b s=%h required v=1 s=%h",
                   cyc, bus8.out_valid, bus8.sum, first_res);
        end
      end
      if (cyc >= 4) begin
        checks++;
        if (bus8.out_valid !== 1'b1) begin
          failures++;
          $display("FAIL bp_stream_gap cyc=%0d actual out_valid=%b required=1", cyc, bus8.out_valid);
        end
      end
      if (bus8.out_valid === 1'b1 && bus8.out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL bp_extra actual s=%h required no result", bus8.sum);
        end else if (bus8.sum !== exp_q[0]) begin
          failures++;
          $display("FAIL bp_order actual=%h required=%h", bus8.sum, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
        got++;
      end
      if (bus8.in_valid === 1'b1 && bus8.in_ready === 1'b1) begin
        exp_q.push_back(8'h30 + 8'(2 * idx));
        idx++;
      end
    end
    checks++;
    if (got != 5 || idx != 5) begin
      failures++;
      $display("FAIL bp_count actual got=%0d sent=%0d required 5 5", got, idx);
    end
    @(negedge clk);
    bus8.in_valid = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int stale;
    @(negedge clk);
    bus8.out_ready = 1'b1;
    bus8.in_valid  = 1'b1;
    bus8.a         = 8'h11;
    bus8.b         = 8'h22;
    bus8.carry_in  = 1'b0;
    bus8.sub       = 1'b0;
    @(negedge clk);
    bus8.a = 8'h21;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.sum !== 8'h00 || bus8.carry_out !== 1'b0 ||
        bus8.overflow !== 1'b0 || bus8.zero !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs actual v=%b s=%h c=%b o=%b z=%b required all 0",
               bus8.out_valid, bus8.sum, bus8.carry_out, bus8.overflow, bus8.zero);
    end
    @(negedge clk);
    reset_n = 1'b1;
    stale = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (bus8.out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      failures++;
      $display("FAIL midreset_stale actual=%0d cycles valid required=0", stale);
    end
    op8(8'h33, 8'h44, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, "midreset_fresh");
  endtask

  task automatic test_param_sweep();
    logic [18:0] q1[$];
    logic [18:0] q4[$];
    logic [18:0] exp_v;
    logic [18:0] act;
    int l1;
    int l4;
    int acc1;
    int acc4;
    int tail;
    logic done;
    l1 = 0;
    l4 = 0;
    acc1 = 0;
    acc4 = 0;
    tail = 0;
    exp_v = model(16, 16'h1234, 16'h0F0F, 1'b1, 1'b0);
    @(negedge clk);
    sw_out_ready = 1'b1;
    sw_in_valid  = 1'b1;
    sw_a         = 16'h1234;
    sw_b         = 16'h0F0F;
    sw_carry_in  = 1'b1;
    sw_sub       = 1'b0;
    @(negedge clk);
    sw_in_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      if (l1 == 0 && bus1.out_valid === 1'b1) begin
        l1 = n;
        checks++;
        act = {bus1.zero, bus1.overflow, bus1.carry_out, bus1.sum};
        if (act !== exp_v) begin
          failures++;
          $display("FAIL s1_first actual=%h required=%h", act, exp_v);
        end
      end
      if (l4 == 0 && bus4.out_valid === 1'b1) begin
        l4 = n;
        checks++;
        act = {bus4.zero, bus4.overflow, bus4.carry_out, bus4.sum};
        if (act !== exp_v) begin
          failures++;
          $display("FAIL s4_first actual=%h required=%h", act, exp_v);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (l1 != 1) begin
      failures++;
      $display("FAIL s1_latency actual=%0d required=1", l1);
    end
    checks++;
    if (l4 != 4) begin
      failures++;
      $display("FAIL s4_latency actual=%0d required=4", l4);
    end

    for (int cyc = 0; cyc < 6000 && tail < 8; cyc++) begin
      @(negedge clk);
      done = (acc1 >= 1000) && (acc4 >= 1000);
      if (done) tail++;
      sw_in_valid  = done ? 1'b0 : ($urandom_range(0, 9) != 0);
      sw_out_ready = done ? 1'b1 : ($urandom_range(0, 3) != 0);
      sw_a         = 16'($urandom);
      sw_b         = 16'($urandom);
      sw_carry_in  = 1'($urandom);
      sw_sub       = 1'($urandom);
      #1;
      if (bus1.out_valid === 1'b1 && sw_out_ready) begin
        checks++;
        act = {bus1.zero, bus1.overflow, bus1.carry_out, bus1.sum};
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL s1_extra actual=%h required none", act);
        end else begin
          exp_v = q1.pop_front();
          if (act !== exp_v) begin
            failures++;
            $display("FAIL s1_result actual=%h required=%h", act, exp_v);
          end
        end
      end
      if (bus4.out_valid === 1'b1 && sw_out_ready) begin
        checks++;
        act = {bus4.zero, bus4.overflow, bus4.carry_out, bus4.sum};
        if (q4.size() == 0) begin
          failures++;
          $display("FAIL s4_extra actual=%h required none", act);
        end else begin
          exp_v = q4.pop_front();
          if (act !== exp_v) begin
            failures++;
            $display("FAIL s4_result actual=%h required=%h", act, exp_v);
          end
        end
      end
      if (sw_in_valid && bus1.in_ready === 1'b1) begin
        q1.push_back(model(16, sw_a, sw_b, sw_carry_in, sw_sub));
        acc1++;
      end
      if (sw_in_valid && bus4.in_ready === 1'b1) begin
        q4.push_back(model(16, sw_a, sw_b, sw_carry_in, sw_sub));
        acc4++;
      end
    end
    checks++;
    if (acc1 < 1000 || acc4 < 1000 || q1.size() != 0 || q4.size() != 0) begin
      failures++;
      $display("FAIL sweep_drain actual acc1=%0d acc4=%0d left1=%0d left4=%0d required >=1000 >=1000 0 0",
               acc1, acc4, q1.size(), q4.size());
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.carry_in  = 1'b0;
    bus8.sub       = 1'b0;
    sw_in_valid    = 1'b0;
    sw_out_ready   = 1'b0;
    sw_a           = '0;
    sw_b           = '0;
    sw_carry_in    = 1'b0;
    sw_sub         = 1'b0;
    test_reset();
    test_add();
    test_overflow();
    test_sub();
    test_backpressure();
    test_reset_midflight();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
